sram_axi_responder: RTL and testbench

Responder end of the core's sram-like req/addr_ok/data_ok memory interface, as driven by the load/store unit through the MMU. Converts each accepted request into one single-beat AXI4 read (AR/R) or write (AW/W/B) transaction and returns data_ok/rdata. It sits between the data-side MMU output and the AXI crossbar. The top level ties the ID, LEN=0, BURST=INCR and WLAST=1 fields.

---
 rtl/sram_axi_responder.sv | 164 ++++++++++++++++
 tb/tb_sram_axi_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_responder.sv
// Responder for the sram-like req/addr_ok/data_ok interface.
// Each accepted request becomes one single-beat AXI4 read (AR/R) or write (AW/W/B).
module sram_axi_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic [31:0] axi_araddr,
  output logic [2:0]  axi_arsize,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic [31:0] axi_awaddr,
  output logic [2:0]  axi_awsize,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic        axi_bvalid,
  output logic        axi_bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        arvalid_q, arvalid_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic unused_rresp;

  assign ar_hs = arvalid_q && axi_arready;
  assign r_hs  = (state_q == S_R) && axi_rvalid;
  assign aw_hs = awvalid_q && axi_awready;
  assign w_hs  = wvalid_q && axi_wready;
  assign b_hs  = (state_q == S_B) && axi_bvalid;

  // Responses are returned regardless of rresp/bresp.
  assign unused_rresp = ^axi_rresp;

  assign addr_ok = req && (state_q == S_IDLE);
  assign data_ok = r_hs || b_hs;
  assign rdata   = axi_rdata;

  assign axi_araddr  = addr_q;
  assign axi_arsize  = {1'b0, size_q};
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = (state_q == S_R);
  assign axi_awaddr  = addr_q;
  assign axi_awsize  = {1'b0, size_q};
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = (state_q == S_B);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a signal unassigned (no latches).
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          size_d  = size;
          wstrb_d = wstrb;
          wdata_d = wdata;
          if (we) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_AR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (r_hs) state_d = S_IDLE;
      end
      S_WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Handshakes landing this cycle count toward completion.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_B;
      end
      S_B: begin
        if (b_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the request registers are reset too, so AXI payload outputs read as zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_sram_axi_responder.sv
// Self-checking bench for sram_axi_responder: the bench plays AXI slave with chosen
// ready/valid delays and predicts every output cycle from the handshake timing rules.
module tb_sram_axi_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [31:0] axi_araddr, axi_awaddr, axi_wdata, axi_rdata;
  logic [2:0]  axi_arsize, axi_awsize;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [1:0]  axi_rresp;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_axi_responder dut (
    .clk(clk), .reset(reset),
    .req(req), .we(we), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .axi_araddr(axi_araddr), .axi_arsize(axi_arsize), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awsize(axi_awsize), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_addr_ok"}, 32'(addr_ok), 32'd0);
    check({tag, "_data_ok"}, 32'(data_ok), 32'd0);
    check({tag, "_arvalid"}, 32'(axi_arvalid), 32'd0);
    check({tag, "_rready"},  32'(axi_rready), 32'd0);
    check({tag, "_awvalid"}, 32'(axi_awvalid), 32'd0);
    check({tag, "_wvalid"},  32'(axi_wvalid), 32'd0);
    check({tag, "_bready"},  32'(axi_bready), 32'd0);
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, "_araddr"}, axi_araddr, 32'd0);
    check({tag, "_arsize"}, 32'(axi_arsize), 32'd0);
    check({tag, "_awaddr"}, axi_awaddr, 32'd0);
    check({tag, "_wdata"},  axi_wdata, 32'd0);
    check({tag, "_wstrb"},  32'(axi_wstrb), 32'd0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
    size = 2'($urandom); wstrb = 4'($urandom);
    axi_arready = 1'($urandom); axi_awready = 1'($urandom); axi_wready = 1'($urandom);
    axi_rvalid = 1'b0; axi_bvalid = 1'b0; axi_rdata = $urandom; axi_rresp = 2'($urandom);
    @(negedge clk);
    check_all_quiet("idle");
  endtask

  // One transaction from its accept cycle (t=0) to its data_ok cycle. For reads d_a/d_r are
  // the AR-ready and R-valid delays; for writes d_a/d_w/d_r are the AW, W and B delays.
  task automatic run_txn(input bit t_we, input logic [1:0] t_size, input logic [31:0] t_addr,
                         input logic [3:0] t_wstrb, input logic [31:0] t_wdata,
                         input logic [31:0] t_rdata, input int d_a, input int d_w,
                         input int d_r, input bit hold_req);
    int t_a, t_w, t_b, t_done;
    t_a = 1 + d_a;
    t_w = 1 + d_w;
    t_b = ((t_a > t_w) ? t_a : t_w) + 1;
    t_done = t_we ? (t_b + d_r) : (t_a + 1 + d_r);
    for (int t = 0; t <= t_done; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        req = 1'b1; we = t_we; size = t_size; addr = t_addr; wstrb = t_wstrb; wdata = t_wdata;
      end else begin
        req = hold_req ? 1'b1 : 1'($urandom); we = 1'($urandom); size = 2'($urandom);
        addr = $urandom; wstrb = 4'($urandom); wdata = $urandom;
      end
      axi_arready = !t_we && (d_a == 0 || t >= t_a);
      axi_rvalid  = !t_we && (t == t_done);
      axi_rdata   = axi_rvalid ? t_rdata : $urandom;
      axi_rresp   = 2'($urandom);
      axi_awready = t_we && (d_a == 0 || t >= t_a);
      axi_wready  = t_we && (d_w == 0 || t >= t_w);
      axi_bvalid  = t_we && (t == t_done);
      @(negedge clk);
      check("addr_ok", 32'(addr_ok), 32'(t == 0));
      check("data_ok", 32'(data_ok), 32'(t == t_done));
      if (!t_we) begin
        check("arvalid", 32'(axi_arvalid), 32'(t >= 1 && t <= t_a));
        check("rready",  32'(axi_rready),  32'(t > t_a && t <= t_done));
        check("rd_awvalid", 32'(axi_awvalid), 32'd0);
        check("rd_wvalid",  32'(axi_wvalid), 32'd0);
        check("rd_bready",  32'(axi_bready), 32'd0);
        if (t >= 1 && t <= t_a) begin
          check("araddr", axi_araddr, t_addr);
          check("arsize", 32'(axi_arsize), 32'({1'b0, t_size}));
        end
        if (t == t_done) check("rdata", rdata, t_rdata);
      end else begin
        check("awvalid", 32'(axi_awvalid), 32'(t >= 1 && t <= t_a));
        check("wvalid",  32'(axi_wvalid),  32'(t >= 1 && t <= t_w));
        check("bready",  32'(axi_bready),  32'(t >= t_b && t <= t_done));
        check("wr_arvalid", 32'(axi_arvalid), 32'd0);
        check("wr_rready",  32'(axi_rready), 32'd0);
        if (t >= 1 && t <= t_a) begin
          check("awaddr", axi_awaddr, t_addr);
          check("awsize", 32'(axi_awsize), 32'({1'b0, t_size}));
        end
        if (t >= 1 && t <= t_w) begin
          check("wdata", axi_wdata, t_wdata);
          check("wstrb", 32'(axi_wstrb), 32'(t_wstrb));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0; we = 1'b0; size = '0; addr = '0; wstrb = '0; wdata = '0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rvalid = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    #3;
    check_all_quiet("rst");
    check_regs_zero("rst");
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;

    // Zero-wait word load.
    run_txn(1'b0, 2'd2, 32'h1C00_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
    idle_cycle();
    // Byte store with AW delayed (awvalid held 3 cycles), W immediate.
    run_txn(1'b1, 2'd0, 32'h1C00_0003, 4'h8, 32'h5555_5555, 32'h0, 2, 0, 0, 1'b0);
    // W delayed instead of AW, plus a slow B.
    run_txn(1'b1, 2'd1, 32'h1C00_0102, 4'hC, 32'hA5A5_A5A5, 32'h0, 0, 3, 2, 1'b0);
    idle_cycle();
    // Back-to-back with req held: load then store, no gap.
    run_txn(1'b0, 2'd2, 32'h8000_0040, 4'h0, 32'h0, 32'h1234_5678, 0, 0, 0, 1'b1);
    run_txn(1'b1, 2'd2, 32'h8000_0044, 4'hF, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 1'b1);
    idle_cycle();
    // arready held low 10 cycles while req toggles.
    run_txn(1'b0, 2'd1, 32'h0000_1236, 4'h0, 32'h0, 32'h0BAD_F00D, 10, 0, 1, 1'b0);
    idle_cycle();

    // Reset asserted while waiting in R with rvalid low.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h1C00_00F0;
    axi_arready = 1'b1; axi_rvalid = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_rready", 32'(axi_rready), 32'd1);
    reset = 1'b1;
    #1;
    check_all_quiet("async_rst");
    check_regs_zero("async_rst");
    #1 reset = 1'b0;
    run_txn(1'b0, 2'd2, 32'h1C00_0020, 4'h0, 32'h0, 32'h600D_CAFE, 0, 0, 0, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 200; i++) begin
      bit          r_we;
      logic [1:0]  r_size;
      logic [31:0] r_addr;
      logic [3:0]  r_strb;
      int          da, dw, dr;
      r_we   = 1'($urandom);
      r_size = 2'($urandom_range(2, 0));
      r_addr = $urandom;
      r_strb = 4'($urandom);
      da = ($urandom_range(7, 0) == 0) ? int'($urandom_range(8, 4)) : int'($urandom_range(2, 0));
      dw = int'($urandom_range(3, 0));
      dr = int'($urandom_range(3, 0));
      run_txn(r_we, r_size, r_addr, r_strb, $urandom, $urandom, da, dw, dr, 1'($urandom));
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
